// File: rtl/lzx_cnt_pkg.sv
// Shared constants and helpers for the lzx_mod_counter family.
// Holds the direction encoding and the terminal-value function.
package lzx_cnt_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  // Terminal value is MODULUS-1 counting up, 0 counting down; the caller truncates to WIDTH.
  function automatic longint unsigned term_value(input logic dir, input longint unsigned modulus);
    return (dir == CNT_UP) ? (modulus - 64'd1) : 64'd0;
  endfunction

endpackage

// File: rtl/lzx_cnt_term.sv
// Terminal-count detection shared by the counter next-state logic and its TC output.
// Produces TC, at_term (Q at the terminal value for the current direction) and out_of_range.
module lzx_cnt_term
  import lzx_cnt_pkg::*;
#(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  input  logic             cet_n,
  output logic             tc,
  output logic             at_term,
  output logic             out_of_range
);

  localparam logic [WIDTH-1:0] TERM_UP   = WIDTH'(term_value(CNT_UP, MODULUS));
  localparam logic [WIDTH-1:0] TERM_DOWN = WIDTH'(term_value(CNT_DOWN, MODULUS));

  // Anything above MODULUS-1 can only come from an unclamped parallel load.
  assign out_of_range = (q > TERM_UP);
  assign at_term      = (up == CNT_UP) ? (q == TERM_UP) : (q == TERM_DOWN);
  assign tc           = ~cet_n & at_term;

endmodule

// File: rtl/lzx_mod_counter.sv
// Parametrised presettable modulo counter with 161-style load/enable/cascade pins.
// Define LZX_CNT_UPDOWN_EN to add the UP port and down counting; otherwise up-only.
module lzx_mod_counter
  import lzx_cnt_pkg::*;
#(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic             CP,
  input  logic             MR,
  input  logic             PE_n,
  input  logic             CEP_n,
  input  logic             CET_n,
`ifdef LZX_CNT_UPDOWN_EN
  input  logic             UP,
`endif
  input  logic             CLR_WRAP,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             WRAP
);

  logic             dir;
  logic             at_term;
  logic             out_of_range;
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;

`ifdef LZX_CNT_UPDOWN_EN
  localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(term_value(CNT_UP, MODULUS));
  assign dir = UP;
`else
  assign dir = CNT_UP;
`endif

  lzx_cnt_term #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_term (
    .q            (Q),
    .up           (dir),
    .cet_n        (CET_n),
    .tc           (TC),
    .at_term      (at_term),
    .out_of_range (out_of_range)
  );

  always_comb begin
    q_next    = Q;
    // A wrap on the same edge overrides the clear, so the clear is applied first.
    wrap_next = WRAP & ~CLR_WRAP;
    if (!PE_n) begin
      q_next = D;
    end else if (!CEP_n && !CET_n) begin
`ifdef LZX_CNT_UPDOWN_EN
      if (dir == CNT_DOWN) begin
        if (at_term) begin
          q_next    = TERM_UP;
          wrap_next = 1'b1;
        end else begin
          q_next = Q - 1'b1;
        end
      end else
`endif
      if (at_term || out_of_range) begin
        q_next    = '0;
        wrap_next = 1'b1;
      end else begin
        q_next = Q + 1'b1;
      end
    end
  end

  always_ff @(posedge CP) begin
    if (MR) begin
      Q    <= '0;
      WRAP <= 1'b0;
    end else begin
      Q    <= q_next;
      WRAP <= wrap_next;
    end
  end

endmodule
